// File: rtl/i2c_byte_core.sv
// I2C slave byte engine: synchronised bus sampling, START/STOP detection, address match,
// write-byte hand-off to a consumer and read-byte fetch from a producer.
module i2c_byte_core #(
  parameter logic [6:0]  I2C_ADDR = 7'h0F,
  parameter int unsigned HOLD_CYC = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       SCL,
  input  logic       SDA,
  output logic       SDA_pd,
  output logic [7:0] rxd_data,
  output logic       rxd_syn,
  input  logic       rxd_ack,
  input  logic [7:0] txd_data,
  input  logic       txd_syn,
  output logic       txd_ack
);

  localparam int unsigned HW = (HOLD_CYC < 1) ? 1 : $clog2(HOLD_CYC + 1);
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_ACK
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    scl_sync_q, sda_sync_q;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          rw_q, rw_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          pd_q, pd_d;
  logic [7:0]    rxd_data_q, rxd_data_d;
  logic          rxd_syn_q, rxd_syn_d;
  logic          txd_ack_q, txd_ack_d;
  logic          load_tx;

  logic scl_hi, scl_rise, scl_fall, sda_hi, sda_rise, sda_fall, start_det, stop_det;

  // [0],[1] synchronise; [2] is the previous synced value for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[1:0], SCL};
      sda_sync_q <= {sda_sync_q[1:0], SDA};
    end
  end

  assign scl_hi    = scl_sync_q[1];
  assign scl_rise  = scl_sync_q[1] & ~scl_sync_q[2];
  assign scl_fall  = ~scl_sync_q[1] & scl_sync_q[2];
  assign sda_hi    = sda_sync_q[1];
  assign sda_rise  = sda_sync_q[1] & ~sda_sync_q[2];
  assign sda_fall  = ~sda_sync_q[1] & sda_sync_q[2];
  assign start_det = sda_fall & scl_hi;
  assign stop_det  = sda_rise & scl_hi;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rw_q       <= 1'b0;
      hold_q     <= '0;
      pd_q       <= 1'b0;
      rxd_data_q <= '0;
      rxd_syn_q  <= 1'b0;
      txd_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      hold_q     <= hold_d;
      pd_q       <= pd_d;
      rxd_data_q <= rxd_data_d;
      rxd_syn_q  <= rxd_syn_d;
      txd_ack_q  <= txd_ack_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    hold_d     = hold_q;
    pd_d       = pd_q;
    rxd_data_d = rxd_data_q;
    rxd_syn_d  = rxd_syn_q & ~rxd_ack;
    txd_ack_d  = 1'b0;
    load_tx    = 1'b0;

    // SDA_pd is only updated when the hold timer started by an SCL fall expires;
    // the drive value is taken from the state entered on that fall.
    if (hold_q != '0) hold_d = hold_q - HW'(1);
    if (hold_q == HW'(1)) begin
      case (state_q)
        S_ADDR_ACK: pd_d = 1'b1;
        S_WR_ACK: begin
          if (!rxd_syn_q) begin
            pd_d       = 1'b1;
            rxd_data_d = shift_q;
            rxd_syn_d  = 1'b1;
          end else begin
            pd_d      = 1'b0;
            state_d   = S_IDLE;
            bit_cnt_d = '0;
          end
        end
        S_RD_DATA: pd_d = ~shift_q[7];
        default:   pd_d = 1'b0;
      endcase
    end
    if (scl_fall) hold_d = HOLD_LD;

    case (state_q)
      S_ADDR, S_WR_DATA: begin
        if (scl_rise && bit_cnt_q != 4'd8) begin
          shift_d   = {shift_q[6:0], sda_hi};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
        if (scl_fall && bit_cnt_q == 4'd8) begin
          if (state_q == S_WR_DATA) begin
            state_d = S_WR_ACK;
          end else if (shift_q[7:1] == I2C_ADDR) begin
            state_d = S_ADDR_ACK;
            rw_d    = shift_q[0];
          end else begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
          end
        end
      end
      S_ADDR_ACK: begin
        if (scl_fall) begin
          bit_cnt_d = '0;
          if (rw_q) begin
            state_d = S_RD_DATA;
            load_tx = 1'b1;
          end else begin
            state_d = S_WR_DATA;
          end
        end
      end
      S_WR_ACK: begin
        if (scl_fall) begin
          bit_cnt_d = '0;
          state_d   = S_WR_DATA;
        end
      end
      // Count 0 means the first bit is still pending from the entry edge, so that fall must not shift.
      S_RD_DATA: begin
        if (scl_rise && bit_cnt_q != 4'd8) bit_cnt_d = bit_cnt_q + 4'd1;
        if (scl_fall) begin
          if (bit_cnt_q == 4'd8) state_d = S_RD_ACK;
          else if (bit_cnt_q != 4'd0) shift_d = {shift_q[6:0], 1'b1};
        end
      end
      S_RD_ACK: begin
        if (scl_rise) begin
          bit_cnt_d = '0;
          if (!sda_hi) begin
            state_d = S_RD_DATA;
            load_tx = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: ;
    endcase

    if (start_det) begin
      state_d   = S_ADDR;
      bit_cnt_d = '0;
      load_tx   = 1'b0;
    end else if (stop_det) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      hold_d    = HOLD_LD;
      load_tx   = 1'b0;
    end

    if (load_tx) begin
      if (txd_syn) begin
        shift_d   = txd_data;
        txd_ack_d = 1'b1;
      end else begin
        shift_d = '1;
      end
    end
  end

  assign SDA_pd   = pd_q;
  assign rxd_data = rxd_data_q;
  assign rxd_syn  = rxd_syn_q;
  assign txd_ack  = txd_ack_q;

endmodule

// File: tb/tb_i2c_byte_core.sv
// Bench for i2c_byte_core: a bit-banged master on a wired-AND bus, with expected bus/consumer
// values queued as stimulus is driven and compared as the DUT produces them.
module tb_i2c_byte_core;

  localparam int unsigned HOLD = 4;
  localparam int unsigned QCLK = 20;

  logic       clk;
  logic       reset_n;
  logic       SCL;
  logic       SDA;
  logic       sda_m;
  logic       SDA_pd;
  logic [7:0] rxd_data;
  logic       rxd_syn;
  logic       rxd_ack;
  logic [7:0] txd_data;
  logic       txd_syn;
  logic       txd_ack;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  int unsigned since_fall = 0;
  logic        scl_last = 1'b1;
  logic        pd_last = 1'b0;
  logic        syn_last = 1'b0;
  logic        txd_last = 1'b0;
  int unsigned pd_high = 0;
  int unsigned syn_rises = 0;
  int unsigned txd_pulses = 0;
  int unsigned txd_wide = 0;

  assign SDA = sda_m & ~SDA_pd;

  i2c_byte_core #(.I2C_ADDR(7'h0F), .HOLD_CYC(HOLD)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .SCL      (SCL),
    .SDA      (SDA),
    .SDA_pd   (SDA_pd),
    .rxd_data (rxd_data),
    .rxd_syn  (rxd_syn),
    .rxd_ack  (rxd_ack),
    .txd_data (txd_data),
    .txd_syn  (txd_syn),
    .txd_ack  (txd_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic sb_pop(input logic [31:0] act);
    logic [31:0] e;
    string t;
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, act, e);
    end
  endtask

  // SCL cycles since its last falling edge, sampled on the DUT clock
  always @(posedge clk) begin
    scl_last <= SCL;
    if (!SCL && scl_last) since_fall <= 1;
    else                  since_fall <= since_fall + 1;
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (SDA_pd !== pd_last) check_eq("pd_hold_timing", 32'(since_fall), 32'(HOLD + 3));
      if (rxd_syn && !syn_last) begin
        syn_rises <= syn_rises + 1;
        check_eq("syn_with_ack", 32'({pd_last, SDA_pd}), 32'd1);
      end
      if (txd_ack && !txd_last) txd_pulses <= txd_pulses + 1;
      if (txd_ack && txd_last)  txd_wide <= txd_wide + 1;
      if (SDA_pd)               pd_high <= pd_high + 1;
    end
    pd_last  <= SDA_pd;
    syn_last <= rxd_syn;
    txd_last <= txd_ack;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  task automatic wait_q();
    repeat (QCLK) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    SCL   = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    SCL   = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    SCL   = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; wait_q();
    SCL = 1'b1; wait_q(); wait_q();
    SCL = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ack_exp);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    sb_push($sformatf("ack_%02h", b), 32'(ack_exp));
    sda_m = 1'b1; wait_q();
    SCL = 1'b1; wait_q();
    sb_pop(32'(SDA_pd));
    wait_q();
    SCL = 1'b0; wait_q();
  endtask

  task automatic read_byte(input logic [7:0] exp);
    for (int i = 7; i >= 0; i--) begin
      sb_push($sformatf("rd_%02h_bit%0d", exp, i), 32'(exp[i]));
      sda_m = 1'b1; wait_q();
      SCL = 1'b1; wait_q();
      sb_pop(32'(SDA));
      wait_q();
      SCL = 1'b0; wait_q();
    end
  endtask

  task automatic master_ack(input logic ack);
    sda_m = ~ack; wait_q();
    SCL = 1'b1; wait_q(); wait_q();
    SCL = 1'b0; wait_q();
  endtask

  task automatic consume();
    @(negedge clk) rxd_ack = 1'b1;
    @(negedge clk) rxd_ack = 1'b0;
    sb_push("syn_cleared", 32'd0);
    sb_pop(32'(rxd_syn));
  endtask

  task automatic expect_rx(input logic [7:0] d);
    sb_push("rxd_data", 32'(d));
    sb_pop(32'(rxd_data));
    sb_push("rxd_syn", 32'd1);
    sb_pop(32'(rxd_syn));
  endtask

  initial begin
    int unsigned pd_base, syn_base, tx_base;
    rxd_ack = 1'b0; txd_syn = 1'b0; txd_data = '0;
    SCL = 1'b1; sda_m = 1'b1; reset_n = 1'b0;
    repeat (3) @(negedge clk);
    sb_push("rst_pd", 32'd0);   sb_pop(32'(SDA_pd));
    sb_push("rst_syn", 32'd0);  sb_pop(32'(rxd_syn));
    sb_push("rst_data", 32'd0); sb_pop(32'(rxd_data));
    sb_push("rst_txack", 32'd0); sb_pop(32'(txd_ack));
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // basic write: address ACK, data ACK, hand-off held until consumed
    syn_base = syn_rises;
    i2c_start(); send_byte(8'h1E, 1'b1); send_byte(8'hA5, 1'b1); i2c_stop();
    expect_rx(8'hA5);
    repeat (50) @(negedge clk);
    sb_push("syn_held", 32'd1); sb_pop(32'(rxd_syn));
    consume();
    check_eq("wr_syn_rises", 32'(syn_rises - syn_base), 32'd1);

    // foreign addresses, including one differing only in the LSB
    pd_base = pd_high; syn_base = syn_rises;
    i2c_start(); send_byte(8'h20, 1'b0); send_byte(8'h55, 1'b0); send_byte(8'h00, 1'b0); i2c_stop();
    i2c_start(); send_byte(8'h1C, 1'b0); send_byte(8'h66, 1'b0); i2c_stop();
    check_eq("nomatch_pd_high", 32'(pd_high - pd_base), 32'd0);
    check_eq("nomatch_syn", 32'(syn_rises - syn_base), 32'd0);

    // read with NACK; the extra byte probes that the block went idle
    txd_data = 8'h3C; txd_syn = 1'b1; tx_base = txd_pulses;
    i2c_start(); send_byte(8'h1F, 1'b1);
    read_byte(8'h3C); master_ack(1'b0);
    read_byte(8'hFF); i2c_stop();
    check_eq("rd_txack_pulses", 32'(txd_pulses - tx_base), 32'd1);

    // read with ACK reloads; producer empty on reload gives 0xFF
    txd_data = 8'h96; txd_syn = 1'b1; tx_base = txd_pulses;
    i2c_start(); send_byte(8'h1F, 1'b1);
    read_byte(8'h96);
    txd_syn = 1'b0;
    master_ack(1'b1);
    read_byte(8'hFF); master_ack(1'b0); i2c_stop();
    check_eq("rd2_txack_pulses", 32'(txd_pulses - tx_base), 32'd1);

    // overrun: second byte NACKed, first kept
    i2c_start(); send_byte(8'h1E, 1'b1); send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b0); i2c_stop();
    expect_rx(8'h11);
    consume();

    // repeated START mid data byte
    i2c_start(); send_byte(8'h1E, 1'b1);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    i2c_start(); send_byte(8'h1E, 1'b1); send_byte(8'h5A, 1'b1); i2c_stop();
    expect_rx(8'h5A);
    consume();

    // reset while driving a read bit
    txd_data = 8'h00; txd_syn = 1'b1;
    i2c_start(); send_byte(8'h1E, 1'b1); send_byte(8'h77, 1'b1);
    i2c_start(); send_byte(8'h1F, 1'b1);
    sb_push("rd_bit7_driven", 32'd1); sb_pop(32'(SDA_pd));
    sb_push("syn_before_rst", 32'd1); sb_pop(32'(rxd_syn));
    #3 reset_n = 1'b0;
    #1;
    sb_push("arst_pd", 32'd0);    sb_pop(32'(SDA_pd));
    sb_push("arst_syn", 32'd0);   sb_pop(32'(rxd_syn));
    sb_push("arst_data", 32'd0);  sb_pop(32'(rxd_data));
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    pd_base = pd_high; tx_base = txd_pulses;
    read_byte(8'hFF); master_ack(1'b1);
    send_byte(8'h1E, 1'b0); i2c_stop();
    check_eq("post_rst_pd_high", 32'(pd_high - pd_base), 32'd0);
    check_eq("post_rst_txack", 32'(txd_pulses - tx_base), 32'd0);
    txd_syn = 1'b0;
    i2c_start(); send_byte(8'h1E, 1'b1); send_byte(8'h3C, 1'b1); i2c_stop();
    expect_rx(8'h3C);
    consume();

    check_eq("txd_ack_width", 32'(txd_wide), 32'd0);
    check_eq("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
